// File: rtl/wb_write_ctrl.sv
// Writeback initiator: buffers ALU/load results and issues one register-file write per cycle in order.
// Optional macro WB_BYPASS_EN: when the FIFO is empty, an accepted result goes straight to the write port.
module wb_write_ctrl #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_rd,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  output logic                     write,
  output logic [ADDR_W-1:0]        regwriteaddress,
  output logic [DATA_W-1:0]        datain,
  output logic [31:0]              pending_mask,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
  logic [ADDR_W-1:0] rd_mem_d   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];
  logic [PTR_W-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              full, mem_acc, alu_acc, acc, pop, push, byp;
  logic [ADDR_W-1:0] acc_rd;
  logic [DATA_W-1:0] acc_data;

  // Handshake: load unit has priority, one acceptance per cycle.
  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    mem_ready = ~full;
    alu_ready = ~full & ~mem_valid;
    mem_acc   = mem_valid & ~full;
    alu_acc   = alu_valid & ~full & ~mem_valid;
    acc       = mem_acc | alu_acc;
    acc_rd    = mem_acc ? mem_rd   : alu_rd;
    acc_data  = mem_acc ? mem_data : alu_data;
    pop       = (count_q != '0);
`ifdef WB_BYPASS_EN
    byp       = acc & (acc_rd != '0) & ~pop;
`else
    byp       = 1'b0;
`endif
    push      = acc & (acc_rd != '0) & ~byp;
  end

  // Next-state for FIFO storage, pointers, occupancy and the write port.
  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    write_d    = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    if (push) begin
      rd_mem_d[wp_q]   = acc_rd;
      data_mem_d[wp_q] = acc_data;
      wp_d             = wp_q + PTR_W'(1);
    end

    if (pop) begin
      write_d = 1'b1;
      waddr_d = rd_mem_q[rp_q];
      wdata_d = data_mem_q[rp_q];
      rp_d    = rp_q + PTR_W'(1);
    end else if (byp) begin
      write_d = 1'b1;
      waddr_d = acc_rd;
      wdata_d = acc_data;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Scoreboard: every live FIFO entry plus the write port; x0 never pending.
  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        pending_mask[rd_mem_q[PTR_W'(rp_q + PTR_W'(i))]] = 1'b1;
      end
    end
    if (write_q) begin
      pending_mask[waddr_q] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      write_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      write_q    <= write_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign write           = write_q;
  assign regwriteaddress = waddr_q;
  assign datain          = wdata_q;
  assign count           = count_q;

endmodule

// File: tb/tb_wb_write_ctrl.sv
// Bench for wb_write_ctrl: queue-based reference model checked every cycle, plus directed scenarios.
module tb_wb_write_ctrl;

  localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_valid, alu_valid;
  logic [4:0]  mem_rd, alu_rd;
  logic [63:0] mem_data, alu_data;
  logic        mem_ready, alu_ready, write;
  logic [4:0]  regwriteaddress;
  logic [63:0] datain;
  logic [31:0] pending_mask;
  logic [2:0]  count;

  wb_write_ctrl #(.DATA_W(64), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .write(write), .regwriteaddress(regwriteaddress), .datain(datain),
    .pending_mask(pending_mask), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [4:0] rd; logic [63:0] data; } ent_t;
  typedef struct packed { logic [4:0] rd; logic [63:0] data; logic [31:0] cyc; } wr_t;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          chk_en = 1'b0;
  logic [31:0] cyc = '0;
  int          max_count = 0;

  ent_t        mq[$];
  logic        m_write;
  logic [4:0]  m_addr;
  logic [63:0] m_data;
  wr_t         wlog[$];
  logic [63:0] dut_rf [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, write port as three variables.
  always @(posedge clock) begin
    bit          full, macc, aacc, popped;
    logic [4:0]  a_rd;
    logic [63:0] a_data;
    ent_t        e;
    cyc <= cyc + 32'd1;
    if (reset) begin
      mq.delete();
      m_write = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      full   = (mq.size() == DEPTH);
      macc   = mem_valid && !full;
      aacc   = alu_valid && !full && !mem_valid;
      a_rd   = macc ? mem_rd : alu_rd;
      a_data = macc ? mem_data : alu_data;
      popped = (mq.size() != 0);
      if (popped) begin
        e = mq.pop_front();
        m_write = 1'b1; m_addr = e.rd; m_data = e.data;
      end else begin
        m_write = 1'b0;
      end
      if ((macc || aacc) && a_rd != 5'd0) begin
`ifdef WB_BYPASS_EN
        if (!popped) begin
          m_write = 1'b1; m_addr = a_rd; m_data = a_data;
        end else mq.push_back('{rd: a_rd, data: a_data});
`else
        mq.push_back('{rd: a_rd, data: a_data});
`endif
      end
    end
  end

  // Per-cycle compare against the model, and a log of what reaches the register file.
  always @(negedge clock) begin
    logic [31:0] p;
    if (chk_en) begin
      p = '0;
      foreach (mq[i]) p[mq[i].rd] = 1'b1;
      if (m_write) p[m_addr] = 1'b1;
      p[0] = 1'b0;
      chk("mem_ready", 64'(mem_ready), 64'(mq.size() < DEPTH));
      chk("alu_ready", 64'(alu_ready), 64'((mq.size() < DEPTH) && !mem_valid));
      chk("count", 64'(count), 64'(mq.size()));
      chk("write", 64'(write), 64'(m_write));
      chk("waddr", 64'(regwriteaddress), 64'(m_addr));
      chk("wdata", datain, m_data);
      chk("pending", 64'(pending_mask), 64'(p));
      if (int'(count) > max_count) max_count = int'(count);
      if (write === 1'b1) begin
        wlog.push_back('{rd: regwriteaddress, data: datain, cyc: cyc});
        dut_rf[regwriteaddress] = datain;
      end
    end
  end

  task automatic go();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    mem_valid = 1'b0; alu_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    clr();
    repeat (n) go();
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [63:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
  endtask

  task automatic drive_mem(input logic [4:0] rd, input logic [63:0] d);
    mem_valid = 1'b1; mem_rd = rd; mem_data = d;
  endtask

  initial begin
    int i, guard;
    reset = 1'b1;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    foreach (dut_rf[k]) dut_rf[k] = '0;

    go(); chk_en = 1'b1; go();
    reset = 1'b0;
    chk("rst_write", 64'(write), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_pending", 64'(pending_mask), 64'd0);
    chk("rst_waddr", 64'(regwriteaddress), 64'd0);

    // Single ALU result to x5.
    drive_alu(5'd5, 64'hDEAD_BEEF);
    go(); clr();
    chk("t2_pend_n1", 64'(pending_mask), 64'h20);
    chk("t2_write_n1", 64'(write), 64'(LAT == 1));
    go();
    chk("t2_write_n2", 64'(write), 64'(LAT == 2));
    if (LAT == 2) begin
      chk("t2_addr", 64'(regwriteaddress), 64'd5);
      chk("t2_data", datain, 64'hDEAD_BEEF);
      chk("t2_pend_n2", 64'(pending_mask), 64'h20);
    end else begin
      chk("t2_pend_n2", 64'(pending_mask), 64'h0);
    end
    go();
    chk("t2_pend_n3", 64'(pending_mask), 64'h0);
    chk("t2_data_hold", datain, 64'hDEAD_BEEF);

    // Load and ALU in the same cycle.
    wlog.delete();
    drive_mem(5'd3, 64'd33); drive_alu(5'd4, 64'd44);
    @(negedge clock);
    chk("t3_alu_ready0", 64'(alu_ready), 64'd0);
    chk("t3_mem_ready1", 64'(mem_ready), 64'd1);
    go(); mem_valid = 1'b0;
    @(negedge clock);
    chk("t3_alu_ready1", 64'(alu_ready), 64'd1);
    go(); idle(4);
    chk("t3_nwrites", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      chk("t3_first", 64'(wlog[0].rd), 64'd3);
      chk("t3_second", 64'(wlog[1].rd), 64'd4);
      chk("t3_consec", 64'(wlog[1].cyc - wlog[0].cyc), 64'd1);
    end

    // Burst of six loads, one per cycle.
    wlog.delete();
    i = 0; guard = 0;
    while (i < 6 && guard < 60) begin
      drive_mem(5'(10 + i), 64'(100 + i));
      @(negedge clock);
      if (mem_ready) i++;
      go();
      guard++;
    end
    chk("t4_burst_done", 64'(i), 64'd6);
    idle(8);
    chk("t4_nwrites", 64'(wlog.size()), 64'd6);
    if (wlog.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("t4_rd", 64'(wlog[k].rd), 64'(10 + k));
        chk("t4_data", wlog[k].data, 64'(100 + k));
      end
    end
    chk("t4_max_count", 64'(max_count <= DEPTH), 64'd1);

    // Result to x0 is accepted and dropped.
    wlog.delete();
    drive_alu(5'd0, 64'd1);
    @(negedge clock);
    chk("t5_ready", 64'(alu_ready), 64'd1);
    go(); clr();
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_pending", 64'(pending_mask), 64'd0);
    chk("t5_write", 64'(write), 64'd0);
    idle(3);
    chk("t5_nwrites", 64'(wlog.size()), 64'd0);

    // Two writes to x7.
    wlog.delete();
    drive_alu(5'd7, 64'd1);
    go();
    chk("t6_pend7_k1", 64'(pending_mask[7]), 64'd1);
    drive_alu(5'd7, 64'd2);
    go(); clr();
    chk("t6_pend7_k2", 64'(pending_mask[7]), 64'd1);
    go();
    chk("t6_pend7_k3", 64'(pending_mask[7]), 64'(LAT == 2));
    go();
    chk("t6_pend7_k4", 64'(pending_mask[7]), 64'd0);
    idle(2);
    chk("t6_nwrites", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      chk("t6_w0", wlog[0].data, 64'd1);
      chk("t6_w1", wlog[1].data, 64'd2);
    end
    chk("t6_x7", dut_rf[7], 64'd2);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      mem_valid = ($urandom_range(0, 2) == 0);
      mem_rd    = 5'($urandom_range(0, 7));
      mem_data  = {$urandom, $urandom};
      alu_valid = ($urandom_range(0, 1) == 0);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = {$urandom, $urandom};
      reset     = ($urandom_range(0, 49) == 0);
      go();
    end
    reset = 1'b0;

    // Reset held two cycles in the middle of traffic.
    repeat (3) begin
      drive_mem(5'($urandom_range(1, 31)), {$urandom, $urandom});
      drive_alu(5'($urandom_range(1, 31)), {$urandom, $urandom});
      go();
    end
    reset = 1'b1;
    go(); go();
    reset = 1'b0; clr();
    chk("t1_write", 64'(write), 64'd0);
    chk("t1_count", 64'(count), 64'd0);
    chk("t1_pending", 64'(pending_mask), 64'd0);
    wlog.delete();
    idle(6);
    chk("t1_no_writes", 64'(wlog.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
